// File: rtl/led_blinker_multi_if.sv
// Configuration/status bundle for led_blinker_multi.
// master: board control logic (drives writes, observes LEDs).
// slave: the blinker itself.
interface led_blinker_multi_if #(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [1:0]          wr_mode;
  logic [PERIOD_W-1:0] wr_half;
  logic [NUM_CH-1:0]   led;
  logic [NUM_CH-1:0]   done;
  logic                tick;

  modport master (
    output wr_en, wr_ch, wr_mode, wr_half,
    input  led, done, tick
  );

  modport slave (
    input  wr_en, wr_ch, wr_mode, wr_half,
    output led, done, tick
  );
endinterface

// File: rtl/led_blinker_multi.sv
// Multi-channel LED pattern generator.
// One free-running prescaler produces a shared tick.
// Each channel runs one of four modes: OFF, ON, BLINK or ONESHOT.
// Each channel also has its own half-period, counted in ticks.
// Build option LED_INVERT_EN drives led active-low.
// done and tick keep their polarity.
module led_blinker_multi #(
  parameter int NUM_CH   = 4,
  parameter int PRESCALE = 499,
  parameter int PERIOD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  led_blinker_multi_if.slave bus
);

  localparam int PS_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
  logic            tick_q, tick_d;

  mode_e [NUM_CH-1:0]               mode_q, mode_d;
  logic  [NUM_CH-1:0][PERIOD_W-1:0] half_q, half_d;
  logic  [NUM_CH-1:0][PERIOD_W-1:0] cnt_q, cnt_d;
  logic  [NUM_CH-1:0]               state_q, state_d;
  logic  [NUM_CH-1:0]               done_q, done_d;
  logic  [NUM_CH-1:0]               led_q, led_d;

  logic                wr_valid_s;
  logic [PERIOD_W-1:0] wr_half_s;
  mode_e               wr_mode_s;

  // Out-of-range channel indices are dropped.
  // A zero half-period is promoted to one tick.
  assign wr_valid_s = bus.wr_en && (int'(bus.wr_ch) < NUM_CH);
  assign wr_half_s  = (bus.wr_half == {PERIOD_W{1'b0}}) ? PERIOD_W'(1) : bus.wr_half;
  assign wr_mode_s  = mode_e'(bus.wr_mode);

  // Prescaler: count 0..PRESCALE, tick on the cycle after the terminal count.
  always_comb begin
    tick_d = (ps_cnt_q == PS_W'(PRESCALE));
    if (tick_d) begin
      ps_cnt_d = {PS_W{1'b0}};
    end else begin
      ps_cnt_d = ps_cnt_q + PS_W'(1);
    end
  end

  // Per-channel next state: a write has priority over a coincident tick.
  always_comb begin
    mode_d  = mode_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    done_d  = {NUM_CH{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (wr_valid_s && (int'(bus.wr_ch) == ch)) begin
        mode_d[ch]  = wr_mode_s;
        half_d[ch]  = wr_half_s;
        cnt_d[ch]   = {PERIOD_W{1'b0}};
        state_d[ch] = (wr_mode_s != MODE_OFF);
      end else if (tick_q && ((mode_q[ch] == MODE_BLINK) || (mode_q[ch] == MODE_ONESHOT))) begin
        // half >= 1, so half-1 never underflows and the full range is usable
        if (cnt_q[ch] == (half_q[ch] - PERIOD_W'(1))) begin
          cnt_d[ch] = {PERIOD_W{1'b0}};
          case (mode_q[ch])
            MODE_BLINK: begin
              state_d[ch] = ~state_q[ch];
            end
            MODE_ONESHOT: begin
              state_d[ch] = 1'b0;
              mode_d[ch]  = MODE_OFF;
              done_d[ch]  = 1'b1;
            end
            default: begin
              state_d[ch] = state_q[ch];
            end
          endcase
        end else begin
          cnt_d[ch] = cnt_q[ch] + PERIOD_W'(1);
        end
      end else begin
        cnt_d[ch] = cnt_q[ch];
      end
    end
  end

  // Output polarity for the LED pins.
`ifdef LED_INVERT_EN
  assign led_d = ~state_d;
`else
  assign led_d = state_d;
`endif

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_cnt_q <= {PS_W{1'b0}};
      tick_q   <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        mode_q[ch] <= MODE_OFF;
        half_q[ch] <= PERIOD_W'(1);
        cnt_q[ch]  <= {PERIOD_W{1'b0}};
      end
      state_q <= {NUM_CH{1'b0}};
      done_q  <= {NUM_CH{1'b0}};
`ifdef LED_INVERT_EN
      led_q   <= {NUM_CH{1'b1}};
`else
      led_q   <= {NUM_CH{1'b0}};
`endif
    end else begin
      ps_cnt_q <= ps_cnt_d;
      tick_q   <= tick_d;
      mode_q   <= mode_d;
      half_q   <= half_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      done_q   <= done_d;
      led_q    <= led_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.done = done_q;
  assign bus.tick = tick_q;

endmodule
